arm_cpu: RTL and testbench
==========================

// Module: arm_cpu
// PURPOSE
//  5-stage in-order LEGv8 subset core (IF/ID/EX/MEM/WB) with an internal 32x64 register file.
//  Fetches from a combinational instruction cache (IC) and accesses a combinational data memory (Data_Memory).
//  No data forwarding; control hazards are handled by flushing.
// PARAMETERS
//  none (widths fixed: 64-bit datapath, 32-bit instructions)
// PORTS (positional order in existing instantiations: RESET, CLOCK, then as listed)
//  CLOCK           in   1   single clock, all state updates on rising edge
//  RESET           in   1   synchronous, active-high
//  instruction     in   32  IC output for address PC (combinational, same cycle)
//  mem_read_data   in   64  Data_Memory read data (combinational)
//  PC              out  64  fetch address to IC
//  mem_address     out  64  data memory byte address (EX/MEM ALU result)
//  mem_write_data  out  64  store data (EX/MEM Rt value)
//  mem_write       out  1   store strobe; memory writes while high (level, one cycle)
//  mem_read        out  1   load strobe
// BEHAVIOUR
//  Reset (RESET high at a rising edge):
//  - PC, all pipeline registers and all 32 registers clear to 0.
//  - Control bits clear to bubble, so mem_write=mem_read=0 and mem_address=mem_write_data=0 while reset holds.
//  Encoding -> decoding:
//  - Opcodes, matched on instruction[31:21]:
//    ADD=0x458, SUB=0x658, AND=0x450, ORR=0x550 (R-type); LDUR=0x7C2, STUR=0x7C0 (D-type).
//    ADDI=0x244, SUBI=0x344 on [31:22]; CBZ=0xB4 on [31:24]; B=0x05 on [31:26].
//  - Any other encoding is a NOP: no register or memory write, no branch.
//  - Fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
//    imm12=[21:10], zero-extended. DT=[20:12], sign-extended 9b.
//    CBZ off=[23:5], sign-extended 19b. B off=[25:0], sign-extended 26b.
//  Operations:
//  - R-type: Rd = Rn op Rm. I-type: Rd = Rn +/- imm12.
//  - LDUR: Rt = MEM[Rn+DT]. STUR: MEM[Rn+DT] = Rt.
//  - CBZ: taken if Rt==0. B: always taken.
//  - Branch target = PC of the branch + (off<<2), computed in EX.
//  - Arithmetic is 64-bit modulo 2^64; no flags.
//  - X31 reads as 0; writes to X31 are discarded.
//  Pipeline timing:
//  - IF: PC = PC+4 every cycle unless a redirect occurs.
//  - ID: register file read. A write occurring in WB in the same cycle bypasses to the ID read
//    (write-then-read semantics).
//  - MEM: mem_* outputs are driven from the EX/MEM register and are stable for the whole cycle.
//    Load data is captured into MEM/WB.
//  - WB: register write happens at the rising edge ending the WB cycle.
//  - An instruction fetched in cycle n writes back at the edge ending cycle n+4.
//  Branches and flushes:
//  - A taken branch is resolved in MEM. PC loads the target at the end of that cycle.
//  - The 3 younger instructions in IF/ID/EX are flushed to bubbles (no writes).
//  Data hazards:
//  - No interlock. Software must place >=2 instructions between a producer and a consumer.
//  - A closer consumer reads the stale register value; this is defined behaviour, not X.
//  Reset mid-program:
//  - Reset discards all in-flight instructions. No memory write is issued in the reset cycle.
//  - Fetch restarts at PC=0 in the first cycle after RESET deasserts.
//  Internal register values are not cleared by PC wrap.
// STRUCTURE
//  Shared package (legv8_pkg): opcode constants, field positions, ALU op enum (ADD/SUB/AND/ORR/PASSB),
//  and control-bundle struct (reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond, alu_op).
//  One sub-module: legv8_regfile, 32x64 with 2 read ports, 1 write port, WB bypass and X31=0.
//  Decode, ALU and pipeline registers stay inline.
// TESTING
//  - Reset: hold RESET 2 cycles -> PC=0, mem_write=0, mem_read=0.
//    Release -> PC = 0,4,8,... on successive cycles.
//  - ADDI X1,XZR,#5; 2 NOPs; ADDI X2,X1,#7; 2 NOPs; STUR X2,[XZR,#8]
//    -> mem_write=1 with mem_address=8, mem_write_data=12 for exactly one cycle.
//  - SUB wrap: X1=0 then SUBI X3,X1,#1; 2 NOPs; STUR X3,[XZR,#0]
//    -> mem_write_data=0xFFFF_FFFF_FFFF_FFFF.
//  - Load: mem_read_data=0x1234 at address 16. LDUR X4,[XZR,#16]; 2 NOPs; STUR X4,[XZR,#24]
//    -> mem_read=1 at address 16, then a store of 0x1234 to address 24.
//  - Branch: B #3 at PC 0 -> PC reaches 12 the cycle after the branch's MEM stage.
//    Flushed instructions at 4/8 (STURs) produce no mem_write.
//  - CBZ: not taken when Rt=1 (PC keeps +4); taken when Rt=0 with off=-2 -> PC = branch PC - 8.
//    XZR write: ADDI XZR,XZR,#9 then store XZR -> data 0.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_pkg
// Purpose  : Shared LEGv8 subset definitions: opcodes, ALU ops, control
//            bundle and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package legv8_pkg;

   // Opcode values, aligned to the instruction MSB
   localparam logic [10:0] c_op_add  = 11'h458;
   localparam logic [10:0] c_op_sub  = 11'h658;
   localparam logic [10:0] c_op_and  = 11'h450;
   localparam logic [10:0] c_op_orr  = 11'h550;
   localparam logic [10:0] c_op_ldur = 11'h7C2;
   localparam logic [10:0] c_op_stur = 11'h7C0;
   localparam logic [9:0]  c_op_addi = 10'h244;
   localparam logic [9:0]  c_op_subi = 10'h344;
   localparam logic [7:0]  c_op_cbz  = 8'hB4;
   localparam logic [5:0]  c_op_b    = 6'h05;

   // Register field positions
   localparam int c_rd_lsb = 0;
   localparam int c_rn_lsb = 5;
   localparam int c_rm_lsb = 16;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_ORR   = 3'd3,
      ALU_PASSB = 3'd4
   } alu_op_t;

   // All-zero value of this bundle is a bubble
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    branch;
      logic    uncond;
      alu_op_t alu_op;
   } ctrl_t;

   // Control bundle for one instruction; unknown encodings stay a bubble
   function automatic ctrl_t decode(input logic [31:0] instr);
      ctrl_t c;
      c = '0;
      if (instr[31:21] == c_op_add) begin
         c.reg_write = 1'b1; c.alu_op = ALU_ADD;
      end else if (instr[31:21] == c_op_sub) begin
         c.reg_write = 1'b1; c.alu_op = ALU_SUB;
      end else if (instr[31:21] == c_op_and) begin
         c.reg_write = 1'b1; c.alu_op = ALU_AND;
      end else if (instr[31:21] == c_op_orr) begin
         c.reg_write = 1'b1; c.alu_op = ALU_ORR;
      end else if (instr[31:21] == c_op_ldur) begin
         c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
         c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end else if (instr[31:21] == c_op_stur) begin
         c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end else if (instr[31:22] == c_op_addi) begin
         c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end else if (instr[31:22] == c_op_subi) begin
         c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SUB;
      end else if (instr[31:24] == c_op_cbz) begin
         c.branch = 1'b1; c.alu_op = ALU_PASSB;
      end else if (instr[31:26] == c_op_b) begin
         c.branch = 1'b1; c.uncond = 1'b1;
      end
      return c;
   endfunction

   // ALU immediate: sign-extended DT for loads/stores, zero-extended imm12 otherwise
   function automatic logic [63:0] alu_imm(input logic [31:0] instr);
      if (instr[31:21] == c_op_ldur || instr[31:21] == c_op_stur)
         return {{55{instr[20]}}, instr[20:12]};
      else
         return {52'b0, instr[21:10]};
   endfunction

   // Branch word offset, sign-extended
   function automatic logic [63:0] br_off(input logic [31:0] instr);
      if (instr[31:26] == c_op_b)
         return {{38{instr[25]}}, instr[25:0]};
      else
         return {{45{instr[23]}}, instr[23:5]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_regfile.sv
`default_nettype none
// ============================================================================
// Module   : legv8_regfile
// Purpose  : 32x64 register file, 2 read / 1 write ports. X31 reads as zero
//            and ignores writes; a same-cycle write is visible on the reads.
// Revision : 1.0 - initial release
// ============================================================================
module legv8_regfile
   import legv8_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_raddr1,
   input  logic [4:0]  i_raddr2,
   output logic [63:0] o_rdata1,
   output logic [63:0] o_rdata2,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [63:0] i_wdata
);

   logic [63:0] r_regs [0:31];
   logic        w_wr_ok;

   assign w_wr_ok = i_we && (i_waddr != 5'd31);

   // Register storage: cleared on reset, X31 never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (w_wr_ok) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Read ports with write-then-read bypass
   always_comb begin
      o_rdata1 = r_regs[i_raddr1];
      o_rdata2 = r_regs[i_raddr2];
      if (w_wr_ok && i_waddr == i_raddr1) o_rdata1 = i_wdata;
      if (w_wr_ok && i_waddr == i_raddr2) o_rdata2 = i_wdata;
      if (i_raddr1 == 5'd31) o_rdata1 = '0;
      if (i_raddr2 == 5'd31) o_rdata2 = '0;
   end

endmodule
`default_nettype wire

// File: rtl/arm_cpu.sv
`default_nettype none
// ============================================================================
// Module   : arm_cpu
// Purpose  : 5-stage in-order LEGv8 subset core without forwarding; taken
//            branches resolve in MEM and flush the three younger stages.
// Revision : 1.0 - initial release
// ============================================================================
module arm_cpu
   import legv8_pkg::*;
(
   input  logic        RESET,
   input  logic        CLOCK,
   input  logic [31:0] instruction,
   input  logic [63:0] mem_read_data,
   output logic [63:0] PC,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read
);

   // IF/ID
   logic [63:0] r_pc, r_ifid_pc;
   logic [31:0] r_ifid_instr;
   // ID/EX
   ctrl_t       r_idex_ctrl;
   logic [63:0] r_idex_pc, r_idex_a, r_idex_b, r_idex_imm, r_idex_off;
   logic [4:0]  r_idex_rd;
   // EX/MEM
   logic        r_exmem_reg_write, r_exmem_mem_read, r_exmem_mem_write;
   logic        r_exmem_mem_to_reg, r_exmem_branch, r_exmem_uncond, r_exmem_zero;
   logic [63:0] r_exmem_alu, r_exmem_b, r_exmem_target;
   logic [4:0]  r_exmem_rd;
   // MEM/WB
   logic        r_memwb_reg_write, r_memwb_mem_to_reg;
   logic [63:0] r_memwb_alu, r_memwb_rdata;
   logic [4:0]  r_memwb_rd;

   ctrl_t       w_ctrl;
   logic [4:0]  w_rs2;
   logic [63:0] w_rd1, w_rd2, w_alu_b, w_alu, w_target, w_wb_data;
   logic        w_taken;

   // ID: decode; stores and CBZ read Rt on the second port
   assign w_ctrl = decode(r_ifid_instr);
   assign w_rs2  = (w_ctrl.mem_write || w_ctrl.branch) ?
                   r_ifid_instr[c_rd_lsb +: 5] : r_ifid_instr[c_rm_lsb +: 5];

   legv8_regfile u_regfile (
      .clk      (CLOCK),
      .rst      (RESET),
      .i_raddr1 (r_ifid_instr[c_rn_lsb +: 5]),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2),
      .i_we     (r_memwb_reg_write),
      .i_waddr  (r_memwb_rd),
      .i_wdata  (w_wb_data)
   );

   // EX: ALU and branch target
   assign w_alu_b  = r_idex_ctrl.alu_src ? r_idex_imm : r_idex_b;
   assign w_target = r_idex_pc + (r_idex_off << 2);

   // ALU operation select
   always_comb begin
      w_alu = '0;
      case (r_idex_ctrl.alu_op)
         ALU_ADD:   w_alu = r_idex_a + w_alu_b;
         ALU_SUB:   w_alu = r_idex_a - w_alu_b;
         ALU_AND:   w_alu = r_idex_a & w_alu_b;
         ALU_ORR:   w_alu = r_idex_a | w_alu_b;
         ALU_PASSB: w_alu = w_alu_b;
         default:   w_alu = '0;
      endcase
   end

   // MEM: branch decision and memory interface
   assign w_taken        = r_exmem_branch && (r_exmem_uncond || r_exmem_zero);
   assign mem_address    = r_exmem_alu;
   assign mem_write_data = r_exmem_b;
   assign mem_write      = r_exmem_mem_write;
   assign mem_read       = r_exmem_mem_read;

   // WB: result select
   assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_rdata : r_memwb_alu;
   assign PC        = r_pc;

   // Pipeline advance; a taken branch in MEM redirects PC and bubbles IF/ID/EX
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_pc <= '0;
         r_ifid_pc <= '0; r_ifid_instr <= '0;
         r_idex_ctrl <= '0; r_idex_pc <= '0; r_idex_a <= '0; r_idex_b <= '0;
         r_idex_imm <= '0; r_idex_off <= '0; r_idex_rd <= '0;
         r_exmem_reg_write <= 1'b0; r_exmem_mem_read <= 1'b0; r_exmem_mem_write <= 1'b0;
         r_exmem_mem_to_reg <= 1'b0; r_exmem_branch <= 1'b0; r_exmem_uncond <= 1'b0;
         r_exmem_zero <= 1'b0; r_exmem_alu <= '0; r_exmem_b <= '0;
         r_exmem_target <= '0; r_exmem_rd <= '0;
         r_memwb_reg_write <= 1'b0; r_memwb_mem_to_reg <= 1'b0;
         r_memwb_alu <= '0; r_memwb_rdata <= '0; r_memwb_rd <= '0;
      end else begin
         // IF -> ID
         r_pc         <= w_taken ? r_exmem_target : r_pc + 64'd4;
         r_ifid_pc    <= r_pc;
         r_ifid_instr <= w_taken ? 32'h0 : instruction;
         // ID -> EX
         r_idex_ctrl <= w_taken ? ctrl_t'('0) : w_ctrl;
         r_idex_pc   <= r_ifid_pc;
         r_idex_a    <= w_rd1;
         r_idex_b    <= w_rd2;
         r_idex_imm  <= alu_imm(r_ifid_instr);
         r_idex_off  <= br_off(r_ifid_instr);
         r_idex_rd   <= r_ifid_instr[c_rd_lsb +: 5];
         // EX -> MEM
         r_exmem_reg_write  <= !w_taken && r_idex_ctrl.reg_write;
         r_exmem_mem_read   <= !w_taken && r_idex_ctrl.mem_read;
         r_exmem_mem_write  <= !w_taken && r_idex_ctrl.mem_write;
         r_exmem_mem_to_reg <= !w_taken && r_idex_ctrl.mem_to_reg;
         r_exmem_branch     <= !w_taken && r_idex_ctrl.branch;
         r_exmem_uncond     <= !w_taken && r_idex_ctrl.uncond;
         r_exmem_zero       <= (w_alu == 64'd0);
         r_exmem_alu        <= w_alu;
         r_exmem_b          <= r_idex_b;
         r_exmem_target     <= w_target;
         r_exmem_rd         <= r_idex_rd;
         // MEM -> WB
         r_memwb_reg_write  <= r_exmem_reg_write;
         r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
         r_memwb_alu        <= r_exmem_alu;
         r_memwb_rdata      <= mem_read_data;
         r_memwb_rd         <= r_exmem_rd;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arm_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_cpu
// Purpose  : Directed self-checking bench for arm_cpu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_cpu;

   logic        CLOCK, RESET;
   logic [31:0] instruction;
   logic [63:0] mem_read_data, PC, mem_address, mem_write_data;
   logic        mem_write, mem_read;

   logic [31:0] imem [0:63];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   localparam logic [31:0] c_nop = 32'h0;

   arm_cpu dut (
      .RESET          (RESET),
      .CLOCK          (CLOCK),
      .instruction    (instruction),
      .mem_read_data  (mem_read_data),
      .PC             (PC),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write),
      .mem_read       (mem_read)
   );

   assign instruction   = imem[PC[7:2]];
   assign mem_read_data = (mem_address == 64'd16) ? 64'h1234 : 64'h0;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
      return {10'h244, imm, rn, rd};
   endfunction
   function automatic logic [31:0] enc_subi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
      return {10'h344, imm, rn, rd};
   endfunction
   function automatic logic [31:0] enc_stur(input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] dt);
      return {11'h7C0, dt, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] enc_ldur(input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] dt);
      return {11'h7C2, dt, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] enc_b(input logic [25:0] off);
      return {6'h05, off};
   endfunction
   function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] off);
      return {8'hB4, off, rt};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      @(negedge CLOCK);
      cyc++;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = c_nop;
   endtask

   // Hold reset two edges, check the cleared state, then release at cycle 0
   task automatic finish_reset();
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      cyc = 0;
      chk("rst_pc", PC, 64'd0);
      chk("rst_mem_write", {63'b0, mem_write}, 64'd0);
      chk("rst_mem_read", {63'b0, mem_read}, 64'd0);
      chk("rst_mem_address", mem_address, 64'd0);
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      clear_imem();
      @(negedge CLOCK);

      // Reset and sequential fetch
      finish_reset();
      chk("pc_seq0", PC, 64'd0);
      step(); chk("pc_seq1", PC, 64'd4);
      step(); chk("pc_seq2", PC, 64'd8);
      step(); chk("pc_seq3", PC, 64'd12);

      // ADDI chain then store 12 to address 8 (store in MEM at cycle 9)
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_addi(5'd1, 5'd31, 12'd5);
      imem[3] = enc_addi(5'd2, 5'd1, 12'd7);
      imem[6] = enc_stur(5'd2, 5'd31, 9'd8);
      finish_reset();
      for (int k = 0; k <= 12; k++) begin
         chk("addi_mem_write", {63'b0, mem_write}, (k == 9) ? 64'd1 : 64'd0);
         if (k == 9) begin
            chk("addi_addr", mem_address, 64'd8);
            chk("addi_data", mem_write_data, 64'd12);
         end
         step();
      end

      // SUBI wrap: 0 - 1 stored to address 0 at cycle 6
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_subi(5'd3, 5'd1, 12'd1);
      imem[3] = enc_stur(5'd3, 5'd31, 9'd0);
      finish_reset();
      repeat (6) step();
      chk("subi_mem_write", {63'b0, mem_write}, 64'd1);
      chk("subi_addr", mem_address, 64'd0);
      chk("subi_data", mem_write_data, 64'hFFFF_FFFF_FFFF_FFFF);

      // Load 0x1234 from 16 (MEM cycle 3), store to 24 (MEM cycle 6)
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_ldur(5'd4, 5'd31, 9'd16);
      imem[3] = enc_stur(5'd4, 5'd31, 9'd24);
      finish_reset();
      repeat (3) step();
      chk("ld_mem_read", {63'b0, mem_read}, 64'd1);
      chk("ld_addr", mem_address, 64'd16);
      chk("ld_no_write", {63'b0, mem_write}, 64'd0);
      repeat (3) step();
      chk("ld_st_write", {63'b0, mem_write}, 64'd1);
      chk("ld_st_addr", mem_address, 64'd24);
      chk("ld_st_data", mem_write_data, 64'h1234);

      // B #3: flushed stores at 4/8/12 never write; the refetched store at 12 does (cycle 7)
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_b(26'd3);
      imem[1] = enc_stur(5'd31, 5'd31, 9'd0);
      imem[2] = enc_stur(5'd31, 5'd31, 9'd0);
      imem[3] = enc_stur(5'd31, 5'd31, 9'd40);
      finish_reset();
      for (int k = 0; k <= 9; k++) begin
         chk("b_mem_write", {63'b0, mem_write}, (k == 7) ? 64'd1 : 64'd0);
         if (k == 3) chk("b_pc_mem_cycle", PC, 64'd12);
         if (k == 4) chk("b_pc_target", PC, 64'd12);
         if (k == 5) chk("b_pc_after", PC, 64'd16);
         if (k == 7) chk("b_st_addr", mem_address, 64'd40);
         step();
      end

      // CBZ X6 (=1) at 12 not taken; CBZ XZR,-2 at 16 taken -> PC 8
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_addi(5'd6, 5'd31, 12'd1);
      imem[3] = enc_cbz(5'd6, 19'h7FFFE);
      imem[4] = enc_cbz(5'd31, 19'h7FFFE);
      finish_reset();
      repeat (7) step();
      chk("cbz_not_taken_pc", PC, 64'd28);
      step();
      chk("cbz_taken_pc", PC, 64'd8);
      step();
      chk("cbz_taken_pc_next", PC, 64'd12);

      // Write to XZR is discarded; storing XZR yields 0
      RESET = 1'b1;
      clear_imem();
      imem[0] = enc_addi(5'd31, 5'd31, 12'd9);
      imem[3] = enc_stur(5'd31, 5'd31, 9'd32);
      finish_reset();
      repeat (6) step();
      chk("xzr_mem_write", {63'b0, mem_write}, 64'd1);
      chk("xzr_addr", mem_address, 64'd32);
      chk("xzr_data", mem_write_data, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
